grf_write_arbiter: RTL and testbench

//   Shares the single GRF write port between the W-stage writeback (priority) and a

---
 rtl/grf_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_grf_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// grf_write_arbiter : shares the GRF write port between W-stage writeback and
//                     a buffered long-latency X requester.  Rev 1.0
// ============================================================================
module grf_write_arbiter #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w_we,
   input  logic [4:0]       w_addr,
   input  logic [31:0]      w_wd,
   input  logic [31:0]      w_pc,
   input  logic             x_req,
   output logic             x_ready,
   input  logic [4:0]       x_addr,
   input  logic [31:0]      x_wd,
   input  logic [31:0]      x_pc,
   input  logic [4:0]       q_addr1,
   input  logic [4:0]       q_addr2,
   output logic             q_pend1,
   output logic             q_pend2,
   output logic             stall,
   output logic [CNT_W-1:0] fifo_cnt,
   output logic             grf_we,
   output logic [4:0]       grf_addr,
   output logic [31:0]      grf_wd,
   output logic [31:0]      grf_pc
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DEPTH-1:0]        ent_live, hit1, hit2;
   logic [DEPTH-1:0][4:0]   ent_addr;
   logic [DEPTH-1:0][31:0]  ent_wd, ent_pc;
   logic                    w_act, push, pop, full, head_live;

   assign full      = (cnt_q == FULL_CNT);
   assign w_act     = !reset && w_we && (w_addr != 5'd0);
   assign x_ready   = !reset && !full;
   assign stall     = !reset && full;
   assign fifo_cnt  = reset ? '0 : cnt_q;
   assign push      = x_req && x_ready && (x_addr != 5'd0);
   assign head_live = (cnt_q != '0) && ent_live[rd_ptr_q];
   // A dead head drains even while W owns the port.
   assign pop       = (cnt_q != '0) && (!ent_live[rd_ptr_q] || !w_act);
   assign q_pend1   = !reset && (q_addr1 != 5'd0) && (|hit1);
   assign q_pend2   = !reset && (q_addr2 != 5'd0) && (|hit2);

   always_comb begin
      grf_we   = 1'b0;
      grf_addr = 5'd0;
      grf_wd   = 32'd0;
      grf_pc   = 32'd0;
      if (w_act) begin
         grf_we   = 1'b1;
         grf_addr = w_addr;
         grf_wd   = w_wd;
         grf_pc   = w_pc;
      end else if (!reset && head_live) begin
         grf_we   = 1'b1;
         grf_addr = ent_addr[rd_ptr_q];
         grf_wd   = ent_wd[rd_ptr_q];
         grf_pc   = ent_pc[rd_ptr_q];
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (pop)
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push)
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      logic        live_q, live_d;
      logic [4:0]  addr_q, addr_d;
      logic [31:0] wd_q, wd_d, pc_q, pc_d;

      // Squash first, then a same-cycle accept re-arms the slot as the younger write.
      always_comb begin
         live_d = live_q;
         addr_d = addr_q;
         wd_d   = wd_q;
         pc_d   = pc_q;
         if (w_act && live_q && (addr_q == w_addr))
            live_d = 1'b0;
         if (pop && (rd_ptr_q == PTR_W'(g)))
            live_d = 1'b0;
         if (push && (wr_ptr_q == PTR_W'(g))) begin
            live_d = 1'b1;
            addr_d = x_addr;
            wd_d   = x_wd;
            pc_d   = x_pc;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            live_q <= 1'b0;
            addr_q <= 5'd0;
            wd_q   <= 32'd0;
            pc_q   <= 32'd0;
         end else begin
            live_q <= live_d;
            addr_q <= addr_d;
            wd_q   <= wd_d;
            pc_q   <= pc_d;
         end
      end

      assign ent_live[g] = live_q;
      assign ent_addr[g] = addr_q;
      assign ent_wd[g]   = wd_q;
      assign ent_pc[g]   = pc_q;
      assign hit1[g]     = live_q && (addr_q == q_addr1);
      assign hit2[g]     = live_q && (addr_q == q_addr2);
   end

endmodule
`default_nettype wire

// File: tb/tb_grf_write_arbiter.sv
`default_nettype none
// Randomized scoreboard bench for grf_write_arbiter against a queue-based model.
module tb_grf_write_arbiter;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             w_we, x_req, x_ready, q_pend1, q_pend2, stall, grf_we;
   logic [4:0]       w_addr, x_addr, q_addr1, q_addr2, grf_addr;
   logic [31:0]      w_wd, w_pc, x_wd, x_pc, grf_wd, grf_pc;
   logic [CNT_W-1:0] fifo_cnt;

   grf_write_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .w_we(w_we), .w_addr(w_addr), .w_wd(w_wd), .w_pc(w_pc),
      .x_req(x_req), .x_ready(x_ready), .x_addr(x_addr), .x_wd(x_wd), .x_pc(x_pc),
      .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2),
      .stall(stall), .fifo_cnt(fifo_cnt),
      .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd), .grf_pc(grf_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [31:0] pc;
      logic        live;
   } ent_t;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] p;
   } wr_t;

   ent_t mq[$];
   wr_t  sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   e_we, e_ready, e_stall, e_p1, e_p2;
   int   e_cnt;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Expected combinational view of the current cycle from the model.
   task automatic model_comb();
      bit  wact;
      wr_t w;
      wact    = !reset && w_we && (w_addr != 5'd0);
      e_ready = !reset && (mq.size() < DEPTH);
      e_stall = !reset && (mq.size() == DEPTH);
      e_cnt   = reset ? 0 : mq.size();
      e_p1    = 1'b0;
      e_p2    = 1'b0;
      if (!reset) begin
         foreach (mq[i]) begin
            if (mq[i].live && q_addr1 != 5'd0 && mq[i].addr == q_addr1) e_p1 = 1'b1;
            if (mq[i].live && q_addr2 != 5'd0 && mq[i].addr == q_addr2) e_p2 = 1'b1;
         end
      end
      e_we = 1'b0;
      if (wact) begin
         e_we = 1'b1;
         w    = '{a: w_addr, d: w_wd, p: w_pc};
      end else if (!reset && mq.size() > 0 && mq[0].live) begin
         e_we = 1'b1;
         w    = '{a: mq[0].addr, d: mq[0].wd, p: mq[0].pc};
      end
      if (e_we) sbq.push_back(w);
   endtask

   // Model state advance at the clock edge.
   task automatic model_seq();
      bit wact, acc;
      if (reset) begin
         mq.delete();
      end else begin
         wact = w_we && (w_addr != 5'd0);
         acc  = x_req && (mq.size() < DEPTH) && (x_addr != 5'd0);
         if (mq.size() > 0 && (!mq[0].live || !wact)) void'(mq.pop_front());
         if (wact) begin
            foreach (mq[i]) if (mq[i].addr == w_addr) mq[i].live = 1'b0;
         end
         if (acc) mq.push_back('{addr: x_addr, wd: x_wd, pc: x_pc, live: 1'b1});
      end
   endtask

   task automatic step(input bit rst, input bit wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input bit xr, input logic [4:0] xa, input logic [31:0] xd,
                       input logic [4:0] q1, input logic [4:0] q2);
      reset   = rst;
      w_we    = wwe;
      w_addr  = wa;
      w_wd    = wd;
      w_pc    = $urandom;
      x_req   = xr;
      x_addr  = xa;
      x_wd    = xd;
      x_pc    = $urandom;
      q_addr1 = q1;
      q_addr2 = q2;
      model_comb();
      @(negedge clk);
      check("x_ready", {31'd0, x_ready}, {31'd0, e_ready});
      check("stall", {31'd0, stall}, {31'd0, e_stall});
      check("fifo_cnt", {30'd0, fifo_cnt}, e_cnt);
      check("q_pend1", {31'd0, q_pend1}, {31'd0, e_p1});
      check("q_pend2", {31'd0, q_pend2}, {31'd0, e_p2});
      check("grf_we", {31'd0, grf_we}, {31'd0, e_we});
      if (!e_we) check("grf_idle_fields", {grf_addr != 5'd0 || grf_wd != 32'd0 || grf_pc != 32'd0}, 32'd0);
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic idle(input logic [4:0] q1);
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, q1, 5'd0);
   endtask

   // Monitor: every presented GRF write must match the oldest expected write.
   always @(negedge clk) begin : mon
      wr_t w;
      if (grf_we === 1'b1) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL grf_unexpected_write: got addr %0h wd %0h expected none", grf_addr, grf_wd);
         end else begin
            w = sbq.pop_front();
            check("grf_addr", {27'd0, grf_addr}, {27'd0, w.a});
            check("grf_wd", grf_wd, w.d);
            check("grf_pc", grf_pc, w.p);
         end
      end
   end

   initial begin
      reset = 1'b1; w_we = 1'b0; w_addr = '0; w_wd = '0; w_pc = '0;
      x_req = 1'b0; x_addr = '0; x_wd = '0; x_pc = '0; q_addr1 = '0; q_addr2 = '0;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 5'd3, 32'h5, 1, 5'd4, 32'h6, 5'd4, 5'd3);

      // single X write, one-cycle latency
      step(0, 0, 0, 0, 1, 5'd8, 32'h11, 5'd8, 0);
      idle(5'd8);
      idle(5'd8);

      // W priority over a buffered X write
      step(0, 0, 0, 0, 1, 5'd9, 32'h22, 5'd9, 0);
      repeat (3) step(0, 1, 5'd10, 32'h33, 0, 0, 0, 5'd9, 5'd10);
      idle(5'd9);
      idle(5'd9);

      // fill buffer while W busy; third request is held until x_ready
      step(0, 1, 5'd20, 32'h1, 1, 5'd1, 32'hA1, 5'd1, 5'd2);
      step(0, 1, 5'd21, 32'h2, 1, 5'd2, 32'hA2, 5'd1, 5'd2);
      step(0, 1, 5'd22, 32'h3, 1, 5'd3, 32'hA3, 5'd3, 5'd2);
      step(0, 1, 5'd23, 32'h4, 1, 5'd3, 32'hA3, 5'd3, 5'd2);
      repeat (4) step(0, 0, 0, 0, 1, 5'd3, 32'hA3, 5'd3, 5'd1);
      repeat (3) idle(5'd3);

      // squash by a younger W write
      step(0, 0, 0, 0, 1, 5'd5, 32'hAA, 5'd5, 0);
      step(0, 1, 5'd5, 32'hBB, 0, 0, 0, 5'd5, 0);
      repeat (3) idle(5'd5);

      // same-cycle W and X to one register: X is younger and survives
      step(0, 1, 5'd6, 32'h1, 1, 5'd6, 32'h2, 5'd6, 0);
      repeat (2) idle(5'd6);

      // reset with a full buffer, then address-0 requests
      step(0, 1, 5'd11, 32'h7, 1, 5'd12, 32'hC1, 5'd12, 5'd13);
      step(0, 1, 5'd11, 32'h8, 1, 5'd13, 32'hC2, 5'd12, 5'd13);
      step(1, 0, 0, 0, 0, 0, 0, 5'd12, 5'd13);
      repeat (2) idle(5'd12);
      step(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
      repeat (2) idle(5'd0);

      // randomized traffic with a narrow register range to force collisions
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)),
              $urandom, ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      repeat (4) idle(5'd0);
      check("scoreboard_drained", sbq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
